// File: rtl/bf_loader_if.sv
// rtl/bf_loader_if.sv - Source byte stream, instruction-memory write port and status of bf_loader.
interface bf_loader_if #(
  parameter int ADDR_W = 13
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              in_last;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [ADDR_W-1:0] prog_len;

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_data, done, error, err_code, prog_len
  );

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data, done, error, err_code, prog_len
  );
endinterface

// File: rtl/bf_loader.sv
// rtl/bf_loader.sv - Compiles Brainfuck source bytes into 16-bit instructions with bracket resolution.
// Defining BF_LOADER_RLE_EN enables run-length merging of + - > <.
module bf_loader #(
  parameter int ADDR_W      = 13,
  parameter int STACK_DEPTH = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  bf_loader_if.slave bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [2:0] OP_OUT   = 3'd4;
  localparam logic [2:0] OP_IN    = 3'd5;
  localparam logic [2:0] OP_OPEN  = 3'd6;
  localparam logic [2:0] OP_CLOSE = 3'd7;

  typedef enum logic [2:0] {S_LOAD, S_PATCH, S_FLUSH, S_TERM, S_DONE, S_ERROR} state_t;

  state_t            state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic [2:0]        pend_op_q, pend_op_d;
  logic [12:0]       pend_arg_q, pend_arg_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              last_q, last_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [ADDR_W-1:0] prog_len_q, prog_len_d;

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic              push_en;
  logic [SP_W-1:0]   sp_m1;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] new_addr;
  logic              is_cmd;
  logic [2:0]        byte_op;
  logic              merge;
  logic              accept;
  logic              stack_empty;
  logic              stack_full;

  always_comb begin
    is_cmd  = 1'b1;
    byte_op = 3'd0;
    case (bus.in_data)
      8'h2B:   byte_op = 3'd0;
      8'h2D:   byte_op = 3'd1;
      8'h3E:   byte_op = 3'd2;
      8'h3C:   byte_op = 3'd3;
      8'h2E:   byte_op = OP_OUT;
      8'h2C:   byte_op = OP_IN;
      8'h5B:   byte_op = OP_OPEN;
      8'h5D:   byte_op = OP_CLOSE;
      default: is_cmd  = 1'b0;
    endcase
  end

  assign accept      = bus.in_valid && in_ready_q;
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign sp_m1       = sp_q - SP_W'(1);
  assign stack_top   = stack_q[sp_m1[IDX_W-1:0]];
  // Address the next new instruction (or the terminator) would occupy.
  assign new_addr    = pend_valid_q ? pend_addr_q + ADDR_W'(1) : '0;

`ifdef BF_LOADER_RLE_EN
  assign merge = pend_valid_q && !byte_op[2] && (byte_op == pend_op_q) && (pend_arg_q != 13'h1FFF);
`else
  assign merge = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_op_d    = pend_op_q;
    pend_arg_d   = pend_arg_q;
    pend_addr_d  = pend_addr_q;
    sp_d         = sp_q;
    last_d       = last_q;
    push_en      = 1'b0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = done_q;
    error_d      = error_q;
    err_code_d   = err_code_q;
    prog_len_d   = prog_len_q;

    case (state_q)
      S_LOAD: begin
        if (accept) begin
          last_d = bus.in_last;
          if (bus.in_last) state_d = S_FLUSH;
          if (is_cmd) begin
            if (merge) begin
              pend_arg_d = pend_arg_q + 13'd1;
            end else if (byte_op == OP_CLOSE && stack_empty) begin
              state_d    = S_ERROR;
              error_d    = 1'b1;
              err_code_d = 2'd1;
            end else if (new_addr == ADDR_LAST || (byte_op == OP_OPEN && stack_full)) begin
              state_d    = S_ERROR;
              error_d    = 1'b1;
              err_code_d = 2'd3;
            end else begin
              if (pend_valid_q) begin
                wr_en_d   = 1'b1;
                wr_addr_d = pend_addr_q;
                wr_data_d = {pend_op_q, pend_arg_q};
              end
              pend_valid_d = 1'b1;
              pend_op_d    = byte_op;
              pend_addr_d  = new_addr;
              case (byte_op)
                OP_OPEN: begin
                  pend_arg_d = '0;
                  push_en    = 1'b1;
                  sp_d       = sp_q + SP_W'(1);
                end
                OP_CLOSE: begin
                  pend_arg_d = 13'(stack_top);
                  sp_d       = sp_m1;
                  state_d    = S_PATCH;
                end
                OP_OUT, OP_IN: pend_arg_d = '0;
                default:       pend_arg_d = 13'd1;
              endcase
            end
          end
        end
      end
      S_PATCH: begin
        // Pending holds the ']' at B with arg A: back-fill the '[' at A with B.
        wr_en_d   = 1'b1;
        wr_addr_d = ADDR_W'(pend_arg_q);
        wr_data_d = {OP_OPEN, 13'(pend_addr_q)};
        state_d   = last_q ? S_FLUSH : S_LOAD;
      end
      S_FLUSH: begin
        if (!stack_empty) begin
          state_d    = S_ERROR;
          error_d    = 1'b1;
          err_code_d = 2'd2;
        end else begin
          if (pend_valid_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pend_addr_q;
            wr_data_d = {pend_op_q, pend_arg_q};
          end
          state_d = S_TERM;
        end
      end
      S_TERM: begin
        wr_en_d    = 1'b1;
        wr_addr_d  = new_addr;
        wr_data_d  = '0;
        prog_len_d = new_addr;
        state_d    = S_DONE;
      end
      S_DONE:  done_d  = 1'b1;
      S_ERROR: ;
      default: state_d = S_LOAD;
    endcase

    if ((state_q == S_DONE || state_q == S_ERROR) && bus.start) begin
      state_d      = S_LOAD;
      pend_valid_d = 1'b0;
      pend_op_d    = '0;
      pend_arg_d   = '0;
      pend_addr_d  = '0;
      sp_d         = '0;
      last_d       = 1'b0;
      done_d       = 1'b0;
      error_d      = 1'b0;
      err_code_d   = '0;
      prog_len_d   = '0;
    end

    in_ready_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clock) begin
    if (push_en) stack_q[sp_q[IDX_W-1:0]] <= new_addr;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_LOAD;
      pend_valid_q <= 1'b0;
      pend_op_q    <= '0;
      pend_arg_q   <= '0;
      pend_addr_q  <= '0;
      sp_q         <= '0;
      last_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= '0;
      prog_len_q   <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_op_q    <= pend_op_d;
      pend_arg_q   <= pend_arg_d;
      pend_addr_q  <= pend_addr_d;
      sp_q         <= sp_d;
      last_q       <= last_d;
      in_ready_q   <= in_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      prog_len_q   <= prog_len_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.err_code = err_code_q;
  assign bus.prog_len = prog_len_q;
endmodule

// File: tb/tb_bf_loader.sv
// tb/tb_bf_loader.sv - Randomized and directed bench for bf_loader against a program-list reference model.
module tb_bf_loader;
  localparam int ADDR_W = 13;
`ifdef BF_LOADER_RLE_EN
  localparam bit RLE = 1'b1;
`else
  localparam bit RLE = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  bf_loader_if #(.ADDR_W(ADDR_W)) bus ();

  bf_loader #(.ADDR_W(ADDR_W), .STACK_DEPTH(64)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  src_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] act_q[$];
  int          exp_err;
  int          exp_len;
  int          exp_stop;
  logic        rdy_r1;
  logic        rdy_r2;

  // Each write is captured as {3'b0, addr, data}.
  always @(negedge clock) begin
    if (bus.wr_en === 1'b1) act_q.push_back({3'b0, bus.wr_addr, bus.wr_data});
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int decode(input logic [7:0] c);
    case (c)
      "+": return 0;
      "-": return 1;
      ">": return 2;
      "<": return 3;
      ".": return 4;
      ",": return 5;
      "[": return 6;
      "]": return 7;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] word(input int addr, input int op, input int arg);
    return {3'b0, addr[12:0], op[2:0], arg[12:0]};
  endfunction

  // Compile src_q as a list of (op, arg) instructions and derive the write order.
  task automatic model();
    int ops[$];
    int args[$];
    int stk[$];
    int op, n, a;
    exp_q.delete();
    exp_err  = 0;
    exp_len  = 0;
    exp_stop = src_q.size() - 1;
    for (int i = 0; i < src_q.size(); i++) begin
      op = decode(src_q[i]);
      if (op < 0) continue;
      n = ops.size();
      if (RLE && n > 0 && op < 4 && ops[n-1] == op && args[n-1] < 8191) begin
        args[n-1]++;
        continue;
      end
      if (op == 7 && stk.size() == 0) begin
        exp_err = 1; exp_stop = i; return;
      end
      if (n == 8191 || (op == 6 && stk.size() == 64)) begin
        exp_err = 3; exp_stop = i; return;
      end
      if (n > 0) exp_q.push_back(word(n - 1, ops[n-1], args[n-1]));
      ops.push_back(op);
      args.push_back((op < 4) ? 1 : 0);
      if (op == 6) stk.push_back(n);
      if (op == 7) begin
        a = stk.pop_back();
        args[n] = a;
        exp_q.push_back(word(a, 6, n));
      end
    end
    if (stk.size() != 0) begin
      exp_err = 2; return;
    end
    n = ops.size();
    if (n > 0) exp_q.push_back(word(n - 1, ops[n-1], args[n-1]));
    exp_q.push_back(word(n, 0, 0));
    exp_len = n;
  endtask

  task automatic set_src(input string s);
    src_q.delete();
    for (int i = 0; i < s.len(); i++) src_q.push_back(s[i]);
  endtask

  task automatic gen_random();
    string      alpha = "+-><.,[]x";
    int         depth = 0;
    int         len;
    logic [7:0] c = "+";
    src_q.delete();
    len = $urandom_range(1, 30);
    for (int i = 0; i < len; i++) begin
      if (i == 0 || $urandom_range(0, 1) == 0) c = alpha[$urandom_range(0, 8)];
      if (c == "]" && depth == 0 && $urandom_range(0, 4) != 0) c = "+";
      if (c == "[") depth++;
      else if (c == "]" && depth > 0) depth--;
      src_q.push_back(c);
    end
    if ($urandom_range(0, 5) != 0) begin
      while (depth > 0) begin
        src_q.push_back("]");
        depth--;
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input bit last, output bit ok);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(negedge clock);
      w++;
    end
    ok = (bus.in_ready === 1'b1);
    if (ok) begin
      @(posedge clock);
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (ok && b == 8'h5D) begin
      rdy_r1 = bus.in_ready;
      @(negedge clock);
      rdy_r2 = bus.in_ready;
    end
  endtask

  task automatic run_case(input string name, input bit gaps);
    bit ok = 1'b1;
    int w  = 0;
    model();
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    act_q.delete();
    for (int i = 0; i <= exp_stop && ok; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
      send_byte(src_q[i], i == src_q.size() - 1, ok);
    end
    if (!ok) check_eq($sformatf("%s.ready_timeout", name), 32'd0, 32'd1);
    while (!(bus.done === 1'b1 || bus.error === 1'b1) && w < 40) begin
      @(negedge clock);
      w++;
    end
    repeat (3) @(negedge clock);
    check_eq($sformatf("%s.nwr", name), act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check_eq($sformatf("%s.wr%0d", name, i), act_q[i], exp_q[i]);
    check_eq($sformatf("%s.done", name), bus.done, exp_err == 0);
    check_eq($sformatf("%s.error", name), bus.error, exp_err != 0);
    check_eq($sformatf("%s.err_code", name), bus.err_code, exp_err);
    check_eq($sformatf("%s.prog_len", name), bus.prog_len, exp_len);
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq($sformatf("%s.in_ready", name), bus.in_ready, 0);
    check_eq($sformatf("%s.wr_en", name), bus.wr_en, 0);
    check_eq($sformatf("%s.wr_addr", name), bus.wr_addr, 0);
    check_eq($sformatf("%s.wr_data", name), bus.wr_data, 0);
    check_eq($sformatf("%s.done", name), bus.done, 0);
    check_eq($sformatf("%s.error", name), bus.error, 0);
    check_eq($sformatf("%s.err_code", name), bus.err_code, 0);
    check_eq($sformatf("%s.prog_len", name), bus.prog_len, 0);
  endtask

  initial begin
    bit ok;
    int w;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("reset.ready_after", bus.in_ready, 1);

    set_src("+++.");
    run_case("plus3_out", 1'b1);

    set_src("[-]");
    run_case("loop_clear", 1'b0);
    check_eq("loop_clear.rdy_patch", rdy_r1, 0);
    if (act_q.size() >= 5) begin
      check_eq("loop_clear.w0", act_q[0], 32'h0000_C000);
      check_eq("loop_clear.w1", act_q[1], 32'h0001_2001);
      check_eq("loop_clear.w2", act_q[2], 32'h0000_C002);
      check_eq("loop_clear.w3", act_q[3], 32'h0002_E000);
      check_eq("loop_clear.w4", act_q[4], 32'h0003_0000);
    end

    set_src("[]+");
    run_case("patch_resume", 1'b0);
    check_eq("patch_resume.rdy_patch", rdy_r1, 0);
    check_eq("patch_resume.rdy_load", rdy_r2, 1);

    src_q.delete();
    repeat (300) src_q.push_back(">");
    src_q.push_back("<");
    run_case("run300", 1'b0);

    set_src("]");
    run_case("close_first", 1'b1);
    set_src("[[");
    run_case("open_unmatched", 1'b1);
    src_q.delete();
    repeat (65) src_q.push_back("[");
    run_case("stack_full", 1'b0);

    set_src("a+b+");
    run_case("comments", 1'b1);
    set_src("+");
    run_case("reload", 1'b1);
    if (act_q.size() >= 1) check_eq("reload.w0", act_q[0], 32'h0000_0001);
    set_src("ab");
    run_case("empty", 1'b1);

    src_q.delete();
    repeat (8192) src_q.push_back(".");
    run_case("prog_full", 1'b0);
    src_q.delete();
    repeat (8193) src_q.push_back("+");
    run_case("arg_sat", 1'b0);

    // Reset asserted in the PATCH cycle of a ']'.
    set_src("[]");
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    send_byte("[", 1'b0, ok);
    bus.in_valid = 1'b1;
    bus.in_data  = "]";
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(negedge clock);
      w++;
    end
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("patch_reset");
    @(negedge clock);
    bus.in_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("patch_reset.ready_after", bus.in_ready, 1);

    for (int k = 0; k < 40; k++) begin
      gen_random();
      run_case($sformatf("rnd%0d", k), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
